// File: rtl/ram_bank_pkg.sv
// Shared defaults and helpers for the RAM bank arbiter slice.
// Holds the default bank geometry and the ceiling-log2 helper that sizes
// the round-robin pointers.
package ram_bank_pkg;

    localparam int ADDR_BIT_DEF   = 3;
    localparam int DATA_BIT_DEF   = 16;
    localparam int MEM_HEIGHT_DEF = 8;

    // Ceiling log2; the requester count is at least 2, so the result is >= 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_bank_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req - request vector, bit i belongs to requester i
//   ptr - priority pointer; the search starts at this index and wraps
//   gnt - one-hot grant (all zero when no request is pending)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] rot_s;
    logic [N-1:0] pick_s;

    // Rotate requests so the pointer lands on bit 0, keep the lowest set bit,
    // then rotate the winner back into requester order.
    always_comb begin
        rot_s  = N'({req, req} >> ptr);
        pick_s = rot_s & (~rot_s + ONE);
        gnt    = N'(({pick_s, pick_s} << ptr) >> N);
    end

endmodule

// File: rtl/ram_bank_arbiter.sv
// Shares one registered-read RAM bank between NUM_REQ requesters.
// Independent round-robin arbiters on the write and read ports allow one
// write and one read to issue in the same cycle. Read data returns one cycle
// after the grant with a one-hot rsp_valid. Out-of-range addresses are
// granted but never reach the bank (wr_err / rsp_err flag them).
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data      - per-requester write requests (flattened)
//   wr_gnt, wr_err              - one-hot write grant, dropped-write flag
//   rd_req/rd_addr              - per-requester read requests (flattened)
//   rd_gnt                      - one-hot read grant
//   rsp_valid/rsp_data/rsp_err  - read response, one cycle after rd_gnt
//   bank_*                      - bank control, addresses, data; bank_d_r in
module ram_bank_arbiter
    import ram_bank_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_BIT   = ADDR_BIT_DEF,
    parameter int DATA_BIT   = DATA_BIT_DEF,
    parameter int MEM_HEIGHT = MEM_HEIGHT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           wr_req,
    input  logic [NUM_REQ*ADDR_BIT-1:0]  wr_addr,
    input  logic [NUM_REQ*DATA_BIT-1:0]  wr_data,
    output logic [NUM_REQ-1:0]           wr_gnt,
    input  logic [NUM_REQ-1:0]           rd_req,
    input  logic [NUM_REQ*ADDR_BIT-1:0]  rd_addr,
    output logic [NUM_REQ-1:0]           rd_gnt,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BIT-1:0]          rsp_data,
    output logic                         rsp_err,
    output logic                         wr_err,
    output logic                         bank_en,
    output logic                         bank_we,
    output logic                         bank_re,
    output logic [ADDR_BIT-1:0]          bank_addr_w,
    output logic [DATA_BIT-1:0]          bank_d_w,
    output logic [ADDR_BIT-1:0]          bank_addr_r,
    input  logic [DATA_BIT-1:0]          bank_d_r
);

    localparam int PTR_BIT = clog2(NUM_REQ);
    // One extra bit so MEM_HEIGHT == 2**ADDR_BIT is representable.
    localparam logic [ADDR_BIT:0] MEM_LIMIT = (ADDR_BIT+1)'(MEM_HEIGHT);

    logic [PTR_BIT-1:0] wptr_q, wptr_d;
    logic [PTR_BIT-1:0] rptr_q, rptr_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] wr_arb_s, rd_arb_s;
    logic               wr_in_range_s, rd_in_range_s;

    rr_arbiter #(.N(NUM_REQ), .PW(PTR_BIT)) u_wr_arb (
        .req (wr_req),
        .ptr (wptr_q),
        .gnt (wr_arb_s)
    );

    rr_arbiter #(.N(NUM_REQ), .PW(PTR_BIT)) u_rd_arb (
        .req (rd_req),
        .ptr (rptr_q),
        .gnt (rd_arb_s)
    );

    // Grants, bank muxing, range checks and next-state for the pointers.
    always_comb begin
        wr_gnt      = rst ? {NUM_REQ{1'b0}} : wr_arb_s;
        rd_gnt      = rst ? {NUM_REQ{1'b0}} : rd_arb_s;
        bank_addr_w = {ADDR_BIT{1'b0}};
        bank_d_w    = {DATA_BIT{1'b0}};
        bank_addr_r = {ADDR_BIT{1'b0}};
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                bank_addr_w = wr_addr[i*ADDR_BIT +: ADDR_BIT];
                bank_d_w    = wr_data[i*DATA_BIT +: DATA_BIT];
                wptr_d      = (i == NUM_REQ - 1) ? {PTR_BIT{1'b0}} : PTR_BIT'(i + 1);
            end else begin
                wptr_d = wptr_d;
            end
            if (rd_gnt[i]) begin
                bank_addr_r = rd_addr[i*ADDR_BIT +: ADDR_BIT];
                rptr_d      = (i == NUM_REQ - 1) ? {PTR_BIT{1'b0}} : PTR_BIT'(i + 1);
            end else begin
                rptr_d = rptr_d;
            end
        end
        wr_in_range_s = ({1'b0, bank_addr_w} < MEM_LIMIT);
        rd_in_range_s = ({1'b0, bank_addr_r} < MEM_LIMIT);
        bank_we       = (|wr_gnt) & wr_in_range_s;
        bank_re       = (|rd_gnt) & rd_in_range_s;
        bank_en       = bank_we | bank_re;
        wr_err        = (|wr_gnt) & ~wr_in_range_s;
        rsp_valid_d   = rd_gnt;
        rsp_err_d     = (|rd_gnt) & ~rd_in_range_s;
    end

    // Pointer and response-tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= {PTR_BIT{1'b0}};
            rptr_q      <= {PTR_BIT{1'b0}};
            rsp_valid_q <= {NUM_REQ{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Response outputs. Gated by rst so a read granted just before reset
    // never surfaces; data comes straight from the bank's registered output.
    always_comb begin
        rsp_valid = rst ? {NUM_REQ{1'b0}} : rsp_valid_q;
        rsp_err   = ~rst & rsp_err_q;
        if ((|rsp_valid) && !rsp_err_q) begin
            rsp_data = bank_d_r;
        end else begin
            rsp_data = {DATA_BIT{1'b0}};
        end
    end

endmodule
